// File: rtl/fu_mul_seq.sv
// fu_mul_seq: iterative shift-and-add 32x32 multiplier (low word) that borrows
// the shared ALU/shifter through its operand and select ports.
// Optional build macro FU_MUL_OPSWAP_EN: at accept, the larger operand (unsigned)
// becomes the multiplicand so that latency follows the smaller one.
module fu_mul_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        ready,
    output logic        done,
    output logic [31:0] result,
    output logic        fu_busy,
    output logic [31:0] fu_in1,
    output logic [31:0] fu_in2,
    output logic [4:0]  funct_select,
    output logic        unit_sel,
    input  logic [31:0] fu_out
);

    localparam int unsigned W  = 32;
    localparam int unsigned FW = 5;

    localparam logic [FW-1:0] FUNCT_ADD = 5'b00000;
    localparam logic [FW-1:0] FUNCT_SLL = 5'b00000;
    localparam logic [FW-1:0] FUNCT_SRL = 5'b00001;

    typedef enum logic [2:0] {
        S_IDLE,
        S_EVAL,
        S_ADD,
        S_SHA,
        S_SHB,
        S_DONE
    } state_t;

    state_t          state, state_d;
    logic [W-1:0]    a, a_d;
    logic [W-1:0]    b, b_d;
    logic [W-1:0]    acc, acc_d;
    logic [W-1:0]    result_d;
    logic            ready_d, done_d, fu_busy_d, unit_sel_d;
    logic [W-1:0]    fu_in1_d, fu_in2_d;
    logic [FW-1:0]   funct_select_d;

    // State, datapath and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            a            <= '0;
            b            <= '0;
            acc          <= '0;
            result       <= '0;
            ready        <= 1'b1;
            done         <= 1'b0;
            fu_busy      <= 1'b0;
            fu_in1       <= '0;
            fu_in2       <= '0;
            funct_select <= '0;
            unit_sel     <= 1'b0;
        end else begin
            state        <= state_d;
            a            <= a_d;
            b            <= b_d;
            acc          <= acc_d;
            result       <= result_d;
            ready        <= ready_d;
            done         <= done_d;
            fu_busy      <= fu_busy_d;
            fu_in1       <= fu_in1_d;
            fu_in2       <= fu_in2_d;
            funct_select <= funct_select_d;
            unit_sel     <= unit_sel_d;
        end
    end

    // Next state, datapath updates, and outputs decoded from the next state so
    // that the FU issue lines are valid for the whole cycle of ADD/SHA/SHB.
    always_comb begin
        state_d        = state;
        a_d            = a;
        b_d            = b;
        acc_d          = acc;
        result_d       = result;
        ready_d        = 1'b0;
        done_d         = 1'b0;
        fu_busy_d      = 1'b0;
        fu_in1_d       = '0;
        fu_in2_d       = '0;
        funct_select_d = '0;
        unit_sel_d     = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_d = S_EVAL;
                    acc_d   = '0;
`ifdef FU_MUL_OPSWAP_EN
                    if (op_b > op_a) begin
                        a_d = op_b;
                        b_d = op_a;
                    end else begin
                        a_d = op_a;
                        b_d = op_b;
                    end
`else
                    a_d = op_a;
                    b_d = op_b;
`endif
                end
            end
            S_EVAL: begin
                if (b == '0) begin
                    state_d  = S_DONE;
                    result_d = acc;
                end else if (b[0]) begin
                    state_d = S_ADD;
                end else begin
                    state_d = S_SHA;
                end
            end
            S_ADD: begin
                acc_d   = fu_out;
                state_d = S_SHA;
            end
            S_SHA: begin
                a_d     = fu_out;
                state_d = S_SHB;
            end
            S_SHB: begin
                b_d     = fu_out;
                state_d = S_EVAL;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        case (state_d)
            S_IDLE: ready_d = 1'b1;
            S_DONE: done_d  = 1'b1;
            S_ADD: begin
                fu_busy_d      = 1'b1;
                fu_in1_d       = acc_d;
                fu_in2_d       = a_d;
                unit_sel_d     = 1'b0;
                funct_select_d = FUNCT_ADD;
            end
            S_SHA: begin
                fu_busy_d      = 1'b1;
                fu_in1_d       = a_d;
                fu_in2_d       = W'(1);
                unit_sel_d     = 1'b1;
                funct_select_d = FUNCT_SLL;
            end
            S_SHB: begin
                fu_busy_d      = 1'b1;
                fu_in1_d       = b_d;
                fu_in2_d       = W'(1);
                unit_sel_d     = 1'b1;
                funct_select_d = FUNCT_SRL;
            end
            default: begin
                ready_d = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_fu_mul_seq.sv
// Directed bench for fu_mul_seq with a behavioural model of the shared FU.
module tb_fu_mul_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] op_a, op_b;
    logic        ready, done, fu_busy, unit_sel;
    logic [31:0] result, fu_in1, fu_in2, fu_out;
    logic [4:0]  funct_select;

    int errors   = 0;
    int n_checks = 0;
    bit busy_seen;
    bit rec_en = 1'b0;
    int rec_n  = 0;
    logic [31:0] rec_in1 [16];
    logic [31:0] rec_in2 [16];
    logic        rec_us  [16];
    logic [4:0]  rec_fs  [16];

    fu_mul_seq dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .op_a         (op_a),
        .op_b         (op_b),
        .ready        (ready),
        .done         (done),
        .result       (result),
        .fu_busy      (fu_busy),
        .fu_in1       (fu_in1),
        .fu_in2       (fu_in2),
        .funct_select (funct_select),
        .unit_sel     (unit_sel),
        .fu_out       (fu_out)
    );

    always #5 clk = ~clk;

    // Shared FU: ALU add or logical shifter, combinational.
    always_comb begin
        if (!unit_sel) begin
            fu_out = fu_in1 + fu_in2;
        end else begin
            case (funct_select[1:0])
                2'd0:    fu_out = fu_in1 << fu_in2[4:0];
                2'd1:    fu_out = fu_in1 >> fu_in2[4:0];
                default: fu_out = fu_in1;
            endcase
        end
    end

    // Capture FU issues mid-cycle.
    always @(negedge clk) begin
        if (rec_en && fu_busy && rec_n < 16) begin
            rec_in1[rec_n] = fu_in1;
            rec_in2[rec_n] = fu_in2;
            rec_us[rec_n]  = unit_sel;
            rec_fs[rec_n]  = funct_select;
            rec_n++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one multiply and check latency, result and the done pulse.
    // hold keeps start high afterwards; inj>0 pulses a stray start at that cycle.
    task automatic run_op(input logic [31:0] a_v, input logic [31:0] b_v,
                          input logic [31:0] exp_r, input int exp_lat,
                          input bit hold, input int inj, input string tag);
        int lat;
        bit seen;
        op_a = a_v;
        op_b = b_v;
        start = 1'b1;
        busy_seen = 1'b0;
        for (int w = 0; w < 300 && !ready; w++) begin
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        if (!hold) start = 1'b0;
        chk({tag, "_accepted"}, 32'(ready), 32'd0);
        lat = 1;
        seen = 1'b0;
        while (lat < 300) begin
            if (fu_busy) busy_seen = 1'b1;
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (inj > 0 && lat == inj) begin
                chk({tag, "_ready_busy"}, 32'(ready), 32'd0);
                start = 1'b1;
                op_a = 32'd2;
                op_b = 32'd2;
            end
            if (inj > 0 && lat == inj + 1) start = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_done_seen"}, 32'(seen), 32'd1);
        chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_result"}, result, exp_r);
        @(posedge clk); #1;
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
        chk({tag, "_ready_after"}, 32'(ready), 32'd1);
        chk({tag, "_result_held"}, result, exp_r);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        op_a = '0;
        op_b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_busy", 32'(fu_busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Zero multiplier: straight to DONE, FU never used.
        run_op(32'd123, 32'd0, 32'd0, 2, 1'b0, 0, "b_zero");
        chk("b_zero_no_busy", 32'(busy_seen), 32'd0);

        // 7*6 with FU issue sequence capture.
        rec_n = 0;
        rec_en = 1'b1;
        run_op(32'd7, 32'd6, 32'd42, 13, 1'b0, 0, "m7x6");
        rec_en = 1'b0;
        chk("seq_count", 32'(rec_n), 32'd8);
        chk("seq0_us", 32'(rec_us[0]), 32'd1); chk("seq0_fs", 32'(rec_fs[0]), 32'd0);
        chk("seq0_in1", rec_in1[0], 32'd7);    chk("seq0_in2", rec_in2[0], 32'd1);
        chk("seq1_us", 32'(rec_us[1]), 32'd1); chk("seq1_fs", 32'(rec_fs[1]), 32'd1);
        chk("seq1_in1", rec_in1[1], 32'd6);
        chk("seq2_us", 32'(rec_us[2]), 32'd0); chk("seq2_fs", 32'(rec_fs[2]), 32'd0);
        chk("seq2_in1", rec_in1[2], 32'd0);    chk("seq2_in2", rec_in2[2], 32'd14);
        chk("seq3_us", 32'(rec_us[3]), 32'd1); chk("seq3_in1", rec_in1[3], 32'd14);
        chk("seq4_fs", 32'(rec_fs[4]), 32'd1); chk("seq4_in1", rec_in1[4], 32'd3);
        chk("seq5_us", 32'(rec_us[5]), 32'd0); chk("seq5_in1", rec_in1[5], 32'd14);
        chk("seq5_in2", rec_in2[5], 32'd28);
        chk("seq6_fs", 32'(rec_fs[6]), 32'd0); chk("seq6_in1", rec_in1[6], 32'd28);
        chk("seq7_fs", 32'(rec_fs[7]), 32'd1); chk("seq7_in1", rec_in1[7], 32'd1);
        chk("seq7_us", 32'(rec_us[7]), 32'd1); chk("seq7_in2", rec_in2[7], 32'd1);

        // Asynchronous reset in the middle of 7*6 (cycle N+5).
        op_a = 32'd7;
        op_b = 32'd6;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("pre_rst_busy", 32'(fu_busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("arst_ready", 32'(ready), 32'd1);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_result", result, 32'd0);
        chk("arst_busy", 32'(fu_busy), 32'd0);
        chk("arst_in1", fu_in1, 32'd0);
        chk("arst_in2", fu_in2, 32'd0);
        chk("arst_us", 32'(unit_sel), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Worst case with an ignored start in the middle.
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 130, 1'b0, 50, "worst");

        // Wrap-around.
        run_op(32'h8000_0000, 32'd2, 32'd0, 9, 1'b0, 0, "wrap");

`ifdef FU_MUL_OPSWAP_EN
        run_op(32'd3, 32'h0001_0000, 32'h0003_0000, 10, 1'b0, 0, "swap");
`else
        run_op(32'd3, 32'h0001_0000, 32'h0003_0000, 54, 1'b0, 0, "noswap");
`endif

        // Back-to-back with start held high.
        run_op(32'd5, 32'd3, 32'd15, 10, 1'b1, 0, "b2b0");
        run_op(32'd100, 32'd4, 32'd400, 12, 1'b1, 0, "b2b1");
        run_op(32'hDEAD_BEEF, 32'h10, 32'hEADB_EEF0, 18, 1'b0, 0, "b2b2");

        $display("Result: errors=%0d of %0d checks", errors, n_checks);
        $finish;
    end

endmodule
